// File: rtl/regmap_cmd_bridge_if.sv
// -----------------------------------------------------------------------------
// regmap_cmd_bridge_if
//
// Purpose: bundles every handshake/bus signal of regmap_cmd_bridge.
//   - host command stream : in_data / in_valid / in_ready
//   - response stream     : tx_data / tx_valid / tx_ready
//   - register write port : wr_en / wr_addr / wr_data
//   - register read port  : rd_en / rd_addr / rd_data
//   - status              : busy
//
// Modports:
//   slave  - the bridge itself (consumes commands, drives strobes/responses)
//   master - the environment around it (host link, response sink, regmap)
//
// Handshake rule for both byte streams: a byte moves on a rising clock edge
// where valid && ready are both high. A source that raises valid keeps valid
// and data stable until that edge; ready may change freely.
// -----------------------------------------------------------------------------
interface regmap_cmd_bridge_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  busy;

    modport slave (
        input  in_data, in_valid, tx_ready, rd_data,
        output in_ready, tx_data, tx_valid,
        output wr_en, wr_addr, wr_data, rd_en, rd_addr, busy
    );

    modport master (
        output in_data, in_valid, tx_ready, rd_data,
        input  in_ready, tx_data, tx_valid,
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr, busy
    );
endinterface

// File: rtl/regmap_cmd_bridge.sv
// -----------------------------------------------------------------------------
// regmap_cmd_bridge
//
// Purpose: host-side command parser sitting in front of the configuration
// register map. Turns a byte stream into single-cycle register write strobes
// and read requests, and answers on a response byte stream.
//
//   Write : 0xA5, addr, d0, d1, d2, d3   (little-endian, d0 = bits 7:0)
//           -> one wr_en pulse, then response 0x06 (ACK)
//   Read  : 0x5A, addr
//           -> one rd_en pulse, then 4 response bytes, low byte first
//   Other opcode -> response 0x15 (NAK), no strobe
//
// Only one command is in flight; the parser does not accept new bytes while
// a strobe or a response is pending.
//
// Ports:
//   clk      - system clock
//   rst      - synchronous reset, active-high
//   bus      - regmap_cmd_bridge_if.slave (byte streams, regmap ports, busy)
//   state_o  - current FSM state, for debug / checker binding
//
// Parameters:
//   ADDR_WIDTH     - register address width, must be 8 (one address byte)
//   DATA_WIDTH     - register data width, must be 32 (four data bytes)
//   RD_LATENCY     - cycles from rd_en to valid rd_data (>= 1)
//   TIMEOUT_CYCLES - inter-byte inactivity limit (only with CMD_TIMEOUT_EN)
//
// Build option:
//   CMD_TIMEOUT_EN - when defined, a command that stalls in ADDR or WDATA for
//                    TIMEOUT_CYCLES cycles without a byte is discarded and
//                    answered with NAK. Undefined: the parser waits forever.
//
// Valid/ready: a byte moves on an edge where valid && ready; the bridge holds
// tx_valid/tx_data stable until tx_ready takes the byte.
// -----------------------------------------------------------------------------
module regmap_cmd_bridge #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    regmap_cmd_bridge_if.slave   bus,
    output logic [2:0]           state_o
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("regmap_cmd_bridge: DATA_WIDTH must be 32");
        end
        if (ADDR_WIDTH != 8) begin : g_bad_addr_width
            $error("regmap_cmd_bridge: ADDR_WIDTH must be 8");
        end
        if (RD_LATENCY < 1) begin : g_bad_rd_latency
            $error("regmap_cmd_bridge: RD_LATENCY must be at least 1");
        end
    endgenerate

    localparam logic [7:0] OP_WR = 8'hA5;
    localparam logic [7:0] OP_RD = 8'h5A;
    localparam logic [7:0] ACK   = 8'h06;
    localparam logic [7:0] NAK   = 8'h15;

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_WDATA  = 3'd2,
        S_WRITE  = 3'd3,
        S_RDREQ  = 3'd4,
        S_RDWAIT = 3'd5,
        S_RESP   = 3'd6
    } state_t;

    state_t                state_q;
    logic                  in_ready_q;
    logic                  busy_q;
    logic                  is_wr_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            byte_cnt_q;
    logic [31:0]           wdata_sr_q;
    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  rd_en_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic [LAT_W-1:0]      lat_cnt_q;
    // Response bytes queued low byte first; tx_data is always the low byte.
    logic [31:0]           resp_data_q;
    logic [2:0]            resp_left_q;
    logic                  tx_valid_q;

    logic accept;
    logic tx_done;
    logic timeout_hit;

    assign accept  = bus.in_valid && in_ready_q;
    assign tx_done = tx_valid_q && bus.tx_ready;

`ifdef CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            in_wait;

    // Only the mid-command byte-collection states are timed.
    assign in_wait = (state_q == S_ADDR) || (state_q == S_WDATA);

    always_ff @(posedge clk) begin
        if (rst || !in_wait || accept) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Fires on the cycle whose idle edge would bring the count to the limit.
    assign timeout_hit = in_wait && !accept &&
                         (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT_CYCLES > 0);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            addr_q      <= '0;
            byte_cnt_q  <= '0;
            wdata_sr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            lat_cnt_q   <= '0;
            resp_data_q <= '0;
            resp_left_q <= '0;
            tx_valid_q  <= 1'b0;
        end else begin
            // Strobes are single-cycle; only WDATA/ADDR raise them below.
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (bus.in_data == OP_WR || bus.in_data == OP_RD) begin
                            is_wr_q <= (bus.in_data == OP_WR);
                            state_q <= S_ADDR;
                        end else begin
                            in_ready_q  <= 1'b0;
                            resp_data_q <= {24'd0, NAK};
                            resp_left_q <= 3'd1;
                            tx_valid_q  <= 1'b1;
                            state_q     <= S_RESP;
                        end
                    end
                end

                S_ADDR: begin
                    if (accept) begin
                        if (is_wr_q) begin
                            addr_q     <= bus.in_data;
                            byte_cnt_q <= 2'd0;
                            state_q    <= S_WDATA;
                        end else begin
                            // Read strobe goes out in RDREQ, the next cycle.
                            rd_addr_q  <= bus.in_data;
                            rd_en_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= S_RDREQ;
                        end
                    end else if (timeout_hit) begin
                        in_ready_q  <= 1'b0;
                        resp_data_q <= {24'd0, NAK};
                        resp_left_q <= 3'd1;
                        tx_valid_q  <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end

                S_WDATA: begin
                    if (accept) begin
                        wdata_sr_q <= {bus.in_data, wdata_sr_q[31:8]};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // Publish address and data together with the strobe
                            // so the regmap port never shows a half-built word.
                            wr_data_q  <= {bus.in_data, wdata_sr_q[31:8]};
                            wr_addr_q  <= addr_q;
                            wr_en_q    <= 1'b1;
                            in_ready_q <= 1'b0;
                            state_q    <= S_WRITE;
                        end
                    end else if (timeout_hit) begin
                        in_ready_q  <= 1'b0;
                        resp_data_q <= {24'd0, NAK};
                        resp_left_q <= 3'd1;
                        tx_valid_q  <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end

                S_WRITE: begin
                    resp_data_q <= {24'd0, ACK};
                    resp_left_q <= 3'd1;
                    tx_valid_q  <= 1'b1;
                    state_q     <= S_RESP;
                end

                S_RDREQ: begin
                    lat_cnt_q <= '0;
                    state_q   <= S_RDWAIT;
                end

                S_RDWAIT: begin
                    // The last wait cycle is the one where rd_data is valid.
                    if (lat_cnt_q == LAT_W'(RD_LATENCY - 1)) begin
                        resp_data_q <= bus.rd_data;
                        resp_left_q <= 3'd4;
                        tx_valid_q  <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end

                S_RESP: begin
                    if (tx_done) begin
                        resp_data_q <= {8'd0, resp_data_q[31:8]};
                        if (resp_left_q == 3'd1) begin
                            resp_left_q <= 3'd0;
                            tx_valid_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= S_IDLE;
                        end else begin
                            resp_left_q <= resp_left_q - 3'd1;
                        end
                    end
                end

                default: begin
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    tx_valid_q <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.tx_data  = resp_data_q[7:0];
    assign bus.tx_valid = tx_valid_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.rd_addr  = rd_addr_q;
    assign bus.busy     = busy_q;
    assign state_o      = state_q;

endmodule
